ysyx_23060187_ifetch_mem: RTL and testbench
===========================================

YSYX_23060187_IFETCH_MEM -- requirements
Module: ysyx_23060187_IFETCH_MEM

Interface
REQ-001 SHALL have parameter RESET_PC, default 32'h8000_0000: first fetch address after reset.
REQ-002 SHALL have parameter RAND_DELAY, default 1: 1 enables pseudo-random read latency injection, 0 gives zero extra delay.
REQ-003 SHALL have parameter LFSR_SEED, default 8'hA5: LFSR reset value; must be nonzero.
REQ-004 SHALL have port clk  in  1  the single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst  in  1  reset, asynchronous, active-low.
REQ-006 SHALL have port wbu_valid  in  1  next-PC offer from writeback.
REQ-007 SHALL have port dnpc  in  32  next PC, sampled when wbu_valid && pc_ready.
REQ-008 SHALL have port pc_ready  out  1  block accepts a new PC.
REQ-009 SHALL have port mem_ren  out  1  backing-memory read strobe.
REQ-010 SHALL have port mem_raddr  out  32  word-aligned read address.
REQ-011 SHALL have port mem_rdata  in  32  read data, valid exactly one cycle after the mem_ren cycle.
REQ-012 SHALL have port inst_out  out  32  fetched instruction to the IFU inst_in.
REQ-013 SHALL have port mem_IFU_valid  out  1  inst_out valid.
REQ-014 SHALL have port IFU_mem_ready  in  1  IFU accepts inst_out.
REQ-015 SHALL have port pc_out  out  32  address of the instruction on inst_out.
REQ-016 SHALL have port misalign_err  out  1  sticky: some accepted dnpc had bits [1:0] != 0.

Function
REQ-017 SHALL implement FSM states IDLE, DELAY, READ, CAPT, RESP, WAIT_PC, registered, one transition per cycle.
REQ-018 IDLE SHALL load delay_cnt (2 bits) with lfsr[1:0] if RAND_DELAY else 0; go to READ if the loaded value is 0, else DELAY.
REQ-019 DELAY SHALL decrement delay_cnt each cycle and go to READ in the cycle it reaches 0; 3 is the maximum extra latency.
REQ-020 READ SHALL assert mem_ren=1, mem_raddr={pc[31:2],2'b00} for exactly one cycle, then go to CAPT.
REQ-021 CAPT SHALL latch mem_rdata into inst_out at its closing edge, then go to RESP.
REQ-022 RESP SHALL drive mem_IFU_valid=1, inst_out and pc_out stable until IFU_mem_ready=1 is sampled, then go to WAIT_PC.
REQ-023 WAIT_PC SHALL drive pc_ready=1; on wbu_valid=1 load pc<=dnpc, set misalign_err if dnpc[1:0]!=0, go to IDLE; otherwise hold.
REQ-024 pc_ready, mem_ren and mem_IFU_valid SHALL be 0 in every state except the one named above.
REQ-025 wbu_valid outside WAIT_PC SHALL be ignored; dnpc is not stored.
REQ-026 Latency with zero delay: IDLE to mem_IFU_valid rising = 3 cycles (IDLE, READ, CAPT).
REQ-027 LFSR SHALL be 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, advancing every cycle regardless of state.
REQ-028 Address arithmetic SHALL be 32-bit unsigned, no wrap checking; dnpc=32'hFFFF_FFFC is fetched normally.

Reset
REQ-029 On rst=0, asynchronously: state=IDLE, pc=RESET_PC, inst_out=0, pc_out=RESET_PC, misalign_err=0, lfsr=LFSR_SEED, delay_cnt=0; all strobes 0.
REQ-030 Reset mid-transaction SHALL abandon it; any mem_rdata returned afterwards is discarded.
REQ-031 After rst deasserts, the block SHALL fetch RESET_PC with no wbu_valid required.

Structure
REQ-032 State encodings and the RESET_PC default SHALL live in the shared ysyx_23060187 package.
REQ-033 The LFSR SHALL be a sub-module ysyx_23060187_LFSR8 (seed parameter, lfsr output); the rest stays flat.

Verification
REQ-034 RAND_DELAY=0, memory returns 32'h0000_0413 at 32'h8000_0000, IFU_mem_ready=1 -> mem_ren at cycle 1 after reset release, mem_IFU_valid cycle 3, inst_out=32'h0000_0413, pc_out=32'h8000_0000.
REQ-035 IFU_mem_ready held 0 for 5 cycles in RESP -> mem_IFU_valid and inst_out constant for all 5 cycles, no second mem_ren.
REQ-036 In WAIT_PC, wbu_valid=1, dnpc=32'h8000_0004 -> next mem_raddr=32'h8000_0004; wbu_valid pulsed during RESP -> no effect.
REQ-037 dnpc=32'h8000_0006 -> mem_raddr=32'h8000_0004, misalign_err=1 and remains 1 until reset.
REQ-038 RAND_DELAY=1, 200 fetches -> every gap from IDLE to mem_ren is 1..4 cycles and every value 0..3 of delay occurs.
REQ-039 rst asserted in CAPT -> outputs return to reset values immediately; after release, first mem_raddr=32'h8000_0000.

Source files
------------

// File: rtl/ysyx_23060187_pkg.sv
// Shared definitions for the ysyx_23060187 instruction-fetch slice.
//   RESET_PC_DEF    : default first fetch address after reset
//   ifetch_state_e  : fetch FSM state encoding
//   word_align()    : clears the byte-offset bits of an address
package ysyx_23060187_pkg;

   localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_DELAY   = 3'd1,
      ST_READ    = 3'd2,
      ST_CAPT    = 3'd3,
      ST_RESP    = 3'd4,
      ST_WAIT_PC = 3'd5
   } ifetch_state_e;

   function automatic logic [31:0] word_align(input logic [31:0] addr);
      return {addr[31:2], 2'b00};
   endfunction

endpackage

// File: rtl/ysyx_23060187_LFSR8.sv
// 8-bit Fibonacci LFSR, polynomial x^8+x^6+x^5+x^4+1, free-running.
//   clk  : clock, advances every rising edge
//   rst  : asynchronous active-low reset, loads SEED
//   lfsr : current register value
// SEED must be nonzero, otherwise the register locks at zero.
module ysyx_23060187_LFSR8 #(
   parameter logic [7:0] SEED = 8'hA5
) (
   input  logic       clk,
   input  logic       rst,
   output logic [7:0] lfsr
);

   logic fb;

   assign fb = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) lfsr <= SEED;
      else      lfsr <= {lfsr[6:0], fb};
   end

endmodule

// File: rtl/ysyx_23060187_ifetch_mem.sv
// Instruction fetch memory stage: fetches one word per accepted PC from a
// one-cycle-latency backing memory, optionally inserting 0..3 extra cycles
// of pseudo-random latency before each read, and hands the word to the IFU.
//   clk, rst                  : clock, async active-low reset
//   wbu_valid, dnpc, pc_ready : next-PC handshake from writeback
//   mem_ren, mem_raddr        : read strobe and word-aligned address
//   mem_rdata                 : read data, one cycle after mem_ren
//   inst_out, pc_out          : fetched word and its address
//   mem_IFU_valid, IFU_mem_ready : handshake toward the IFU
//   misalign_err              : sticky flag, a misaligned dnpc was accepted
//
// state      | meaning
// -----------+------------------------------------------------------
// ST_IDLE    | pick extra latency from the LFSR
// ST_DELAY   | burn the extra latency cycles
// ST_READ    | mem_ren pulse with the aligned pc
// ST_CAPT    | memory returns data, latched at the closing edge
// ST_RESP    | present inst_out/pc_out until the IFU accepts
// ST_WAIT_PC | pc_ready, wait for the next pc from writeback
module ysyx_23060187_ifetch_mem
   import ysyx_23060187_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = RESET_PC_DEF,
   parameter int unsigned RAND_DELAY = 1,
   parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        wbu_valid,
   input  logic [31:0] dnpc,
   output logic        pc_ready,
   output logic        mem_ren,
   output logic [31:0] mem_raddr,
   input  logic [31:0] mem_rdata,
   output logic [31:0] inst_out,
   output logic        mem_IFU_valid,
   input  logic        IFU_mem_ready,
   output logic [31:0] pc_out,
   output logic        misalign_err
);

   ifetch_state_e state, state_nxt;
   logic [31:0]   pc;
   logic [1:0]    delay_cnt;
   logic [1:0]    delay_load;
   logic [7:0]    lfsr_val;
   logic          lfsr_unused;

   ysyx_23060187_LFSR8 #(
      .SEED (LFSR_SEED)
   ) u_lfsr (
      .clk  (clk),
      .rst  (rst),
      .lfsr (lfsr_val)
   );

   // Only the two low bits pick the latency; the rest just keep the sequence long.
   assign lfsr_unused = ^lfsr_val[7:2];
   assign delay_load  = (RAND_DELAY != 0) ? lfsr_val[1:0] : 2'd0;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE:    state_nxt = (delay_load == 2'd0) ? ST_READ : ST_DELAY;
         // Leave on the cycle the counter steps from 1 to 0.
         ST_DELAY:   if (delay_cnt <= 2'd1) state_nxt = ST_READ;
         ST_READ:    state_nxt = ST_CAPT;
         ST_CAPT:    state_nxt = ST_RESP;
         ST_RESP:    if (IFU_mem_ready) state_nxt = ST_WAIT_PC;
         ST_WAIT_PC: if (wbu_valid) state_nxt = ST_IDLE;
         default:    state_nxt = ST_IDLE;
      endcase
   end

   always_comb begin
      pc_ready      = 1'b0;
      mem_ren       = 1'b0;
      mem_raddr     = 32'd0;
      mem_IFU_valid = 1'b0;
      case (state)
         ST_READ: begin
            mem_ren   = 1'b1;
            mem_raddr = word_align(pc);
         end
         ST_RESP:    mem_IFU_valid = 1'b1;
         ST_WAIT_PC: pc_ready = 1'b1;
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pc           <= RESET_PC;
         delay_cnt    <= 2'd0;
         inst_out     <= 32'd0;
         pc_out       <= RESET_PC;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            ST_IDLE:  delay_cnt <= delay_load;
            ST_DELAY: if (delay_cnt != 2'd0) delay_cnt <= delay_cnt - 2'd1;
            ST_CAPT: begin
               inst_out <= mem_rdata;
               pc_out   <= pc;
            end
            ST_WAIT_PC: begin
               if (wbu_valid) begin
                  pc <= dnpc;
                  if (dnpc[1:0] != 2'b00) misalign_err <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_ysyx_23060187_ifetch_mem.sv
// Bench for ysyx_23060187_ifetch_mem: dut0 runs without extra latency for
// cycle-exact directed checks, dut1 runs with random latency checked
// against an independent LFSR model.
module tb_ysyx_23060187_ifetch_mem;

   logic        clk;
   logic        rst;

   logic        wbu_valid0, pc_ready0, mem_ren0, valid0, ready0, misalign0;
   logic [31:0] dnpc0, mem_raddr0, mem_rdata0, inst_out0, pc_out0;
   logic        wbu_valid1, pc_ready1, mem_ren1, valid1, ready1, misalign1;
   logic [31:0] dnpc1, mem_raddr1, mem_rdata1, inst_out1, pc_out1;

   logic [7:0]  m_lfsr;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] inst;
      bit          chk_pc;
   } sb_t;
   sb_t sb_q[$];

   int n_cmp = 0;
   int n_bad = 0;
   int hist[4];

   ysyx_23060187_ifetch_mem #(.RESET_PC(32'h8000_0000), .RAND_DELAY(0), .LFSR_SEED(8'hA5)) dut0 (
      .clk(clk), .rst(rst), .wbu_valid(wbu_valid0), .dnpc(dnpc0), .pc_ready(pc_ready0),
      .mem_ren(mem_ren0), .mem_raddr(mem_raddr0), .mem_rdata(mem_rdata0), .inst_out(inst_out0),
      .mem_IFU_valid(valid0), .IFU_mem_ready(ready0), .pc_out(pc_out0), .misalign_err(misalign0));

   ysyx_23060187_ifetch_mem #(.RESET_PC(32'h8000_0000), .RAND_DELAY(1), .LFSR_SEED(8'hA5)) dut1 (
      .clk(clk), .rst(rst), .wbu_valid(wbu_valid1), .dnpc(dnpc1), .pc_ready(pc_ready1),
      .mem_ren(mem_ren1), .mem_raddr(mem_raddr1), .mem_rdata(mem_rdata1), .inst_out(inst_out1),
      .mem_IFU_valid(valid1), .IFU_mem_ready(ready1), .pc_out(pc_out1), .misalign_err(misalign1));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'h8000_0000) return 32'h0000_0413;
      return {a[15:0], ~a[31:16]};
   endfunction

   // One-cycle-latency memories; junk when not read so stray captures show up.
   always @(posedge clk) begin
      mem_rdata0 <= mem_ren0 ? mem_word(mem_raddr0) : 32'hDEAD_BEEF;
      mem_rdata1 <= mem_ren1 ? mem_word(mem_raddr1) : 32'hDEAD_BEEF;
   end

   // Reference LFSR: feedback is the parity of taps 8,6,5,4 (mask 0xB8).
   always @(posedge clk or negedge rst) begin
      if (!rst) m_lfsr <= 8'hA5;
      else      m_lfsr <= {m_lfsr[6:0], ^(m_lfsr & 8'hB8)};
   end

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h want %h", tag, obs, exp);
      end
   endtask

   function automatic bit sig_sel(input int w);
      case (w)
         0: return pc_ready0 === 1'b1;
         1: return mem_ren0 === 1'b1;
         2: return valid0 === 1'b1;
         3: return pc_ready1 === 1'b1;
         default: return mem_ren1 === 1'b1;
      endcase
   endfunction

   task automatic wait_neg(input int w, input string tag);
      bit hit;
      hit = 1'b0;
      for (int i = 0; i < 12 && !hit; i++) begin
         @(negedge clk);
         hit = sig_sel(w);
      end
      if (!hit) check_val(tag, 32'd0, 32'd1);
   endtask

   task automatic push_exp(input logic [31:0] npc, input bit chk_pc);
      sb_t e;
      e.pc     = {npc[31:2], 2'b00};
      e.inst   = mem_word({npc[31:2], 2'b00});
      e.chk_pc = chk_pc;
      sb_q.push_back(e);
   endtask

   task automatic pop_cmp();
      sb_t e;
      if (sb_q.size() == 0) begin
         check_val("sb_underflow", 32'd0, 32'd1);
      end else begin
         e = sb_q.pop_front();
         check_val("inst_out", inst_out0, e.inst);
         if (e.chk_pc) check_val("pc_out", pc_out0, e.pc);
      end
   endtask

   task automatic fetch0(input logic [31:0] npc, input bit chk_pc);
      wait_neg(0, "pc_ready_timeout");
      push_exp(npc, chk_pc);
      wbu_valid0 = 1'b1;
      dnpc0      = npc;
      @(posedge clk); #1;
      wbu_valid0 = 1'b0;
      dnpc0      = 32'd0;
      wait_neg(1, "mem_ren_timeout");
      check_val("mem_raddr", mem_raddr0, {npc[31:2], 2'b00});
      wait_neg(2, "valid_timeout");
      pop_cmp();
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      logic [31:0] exp_inst;
      int          n;
      int          exp_gap;
      bit          hit;

      rst = 1'b0;
      wbu_valid0 = 1'b0; dnpc0 = 32'd0; ready0 = 1'b1;
      wbu_valid1 = 1'b0; dnpc1 = 32'd0; ready1 = 1'b1;
      foreach (hist[i]) hist[i] = 0;

      #12;
      check_val("rst_pc_ready", {31'd0, pc_ready0}, 32'd0);
      check_val("rst_mem_ren", {31'd0, mem_ren0}, 32'd0);
      check_val("rst_valid", {31'd0, valid0}, 32'd0);
      check_val("rst_inst_out", inst_out0, 32'd0);
      check_val("rst_pc_out", pc_out0, 32'h8000_0000);
      check_val("rst_misalign", {31'd0, misalign0}, 32'd0);

      // First fetch after release needs no wbu_valid; exact cycle timing.
      @(negedge clk); rst = 1'b1;
      push_exp(32'h8000_0000, 1'b1);
      @(negedge clk);
      check_val("c1_mem_ren", {31'd0, mem_ren0}, 32'd1);
      check_val("c1_mem_raddr", mem_raddr0, 32'h8000_0000);
      @(negedge clk);
      check_val("c2_mem_ren", {31'd0, mem_ren0}, 32'd0);
      check_val("c2_valid", {31'd0, valid0}, 32'd0);
      @(negedge clk);
      check_val("c3_valid", {31'd0, valid0}, 32'd1);
      pop_cmp();
      @(negedge clk);
      check_val("c4_pc_ready", {31'd0, pc_ready0}, 32'd1);

      fetch0(32'h8000_0004, 1'b1);

      // IFU stalls for 5 RESP cycles; a wbu_valid pulse meanwhile must be ignored.
      wait_neg(0, "pc_ready_timeout");
      push_exp(32'h8000_0008, 1'b1);
      wbu_valid0 = 1'b1; dnpc0 = 32'h8000_0008;
      @(posedge clk); #1;
      wbu_valid0 = 1'b0; ready0 = 1'b0;
      wait_neg(1, "mem_ren_timeout");
      check_val("stall_raddr", mem_raddr0, 32'h8000_0008);
      wait_neg(2, "valid_timeout");
      exp_inst = mem_word(32'h8000_0008);
      for (int k = 0; k < 5; k++) begin
         check_val("stall_valid", {31'd0, valid0}, 32'd1);
         check_val("stall_inst", inst_out0, exp_inst);
         check_val("stall_mem_ren", {31'd0, mem_ren0}, 32'd0);
         check_val("stall_pc_ready", {31'd0, pc_ready0}, 32'd0);
         wbu_valid0 = (k == 2);
         dnpc0      = 32'h1234_5670;
         if (k < 4) @(negedge clk);
      end
      wbu_valid0 = 1'b0;
      dnpc0      = 32'd0;
      ready0     = 1'b1;
      pop_cmp();
      fetch0(32'h8000_000C, 1'b1);

      // Misaligned next PC: aligned read, sticky flag.
      check_val("misalign_before", {31'd0, misalign0}, 32'd0);
      fetch0(32'h8000_0006, 1'b0);
      check_val("misalign_set", {31'd0, misalign0}, 32'd1);
      fetch0(32'h8000_0010, 1'b1);
      check_val("misalign_sticky", {31'd0, misalign0}, 32'd1);

      fetch0(32'hFFFF_FFFC, 1'b1);

      // Reset asserted while in CAPT.
      wait_neg(0, "pc_ready_timeout");
      wbu_valid0 = 1'b1; dnpc0 = 32'h8000_0020;
      @(posedge clk); #1;
      wbu_valid0 = 1'b0; dnpc0 = 32'd0;
      wait_neg(1, "mem_ren_timeout");
      @(posedge clk); #1;
      rst = 1'b0;
      #1;
      sb_q.delete();
      check_val("capt_rst_valid", {31'd0, valid0}, 32'd0);
      check_val("capt_rst_inst", inst_out0, 32'd0);
      check_val("capt_rst_pc_out", pc_out0, 32'h8000_0000);
      check_val("capt_rst_misalign", {31'd0, misalign0}, 32'd0);
      check_val("capt_rst_mem_ren", {31'd0, mem_ren0}, 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;
      push_exp(32'h8000_0000, 1'b1);
      @(negedge clk);
      check_val("post_rst_mem_ren", {31'd0, mem_ren0}, 32'd1);
      check_val("post_rst_raddr", mem_raddr0, 32'h8000_0000);
      wait_neg(2, "valid_timeout");
      pop_cmp();
      check_val("sb_empty", sb_q.size(), 32'd0);

      // Random latency on dut1, predicted from the reference LFSR.
      @(negedge clk); rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      for (int f = 0; f < 200; f++) begin
         exp_gap = 1 + int'(m_lfsr[1:0]);
         n   = 0;
         hit = 1'b0;
         while (!hit && n < 8) begin
            @(negedge clk);
            n++;
            hit = (mem_ren1 === 1'b1);
         end
         check_val("gap", n, exp_gap);
         if (n >= 1 && n <= 4) hist[n-1]++;
         wait_neg(3, "pc_ready1_timeout");
         wbu_valid1 = 1'b1;
         dnpc1      = 32'h8000_0000 + 32'(4 * (f + 1));
         @(posedge clk); #1;
         wbu_valid1 = 1'b0;
         @(negedge clk);
      end
      for (int d = 0; d < 4; d++) check_val("delay_seen", {31'd0, hist[d] != 0}, 32'd1);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
